serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial unsigned subtractor: captures two WIDTH-bit operands on a start strobe and computes `a - b` LSB-first, one bit per clock, through a single full-subtractor cell and a registered borrow. It is the sequential, subtracting counterpart of the adder cells in the combinational arithmetic library. It is used where area matters more than latency, and it reports its result through a start/busy/done handshake.

## Interface
- `WIDTH`, default 8, operand and result width in bits (≥ 2).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend, captured on accepted start.
- `b`  in  WIDTH  subtrahend, captured on accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when result is complete.
- `diff`  out  WIDTH  difference, `(a - b) mod 2^WIDTH`.
- `borrow`  out  1  final borrow, 1 iff `a < b` (unsigned).

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE → RUN:** on `start=1`.
  - Load the `a` and `b` shift registers.
  - Clear the borrow flop, `diff`, and the bit counter.
- **RUN, each cycle:** the full-subtractor computes `d = a0 ^ b0 ^ bin` and `bout = (~a0 & b0) | (~(a0 ^ b0) & bin)`.
  - Operand registers shift right by 1.
  - `d` shifts into `diff` at the MSB, so `diff` shifts right.
  - The borrow flop takes `bout`.
  - The counter increments.
- **RUN → DONE:** after the WIDTH-th bit has been processed (counter reaches WIDTH-1 in that cycle).
- **DONE → IDLE:** unconditional, after one cycle.
- `start` is ignored in RUN and in DONE; no queuing.
- `diff` and `borrow` are intermediate during RUN. They are valid from the DONE cycle and are held until the next accepted start.
- The counter is `$clog2(WIDTH)` bits wide and does not wrap within an operation.

## Timing
- **Reset values:**
  - State is IDLE.
  - `busy=0`, `done=0`, `diff=0`, `borrow=0`.
  - Operand registers, borrow flop, and counter are all 0.
- **Reset mid-RUN:** aborts the operation immediately. The partial result is discarded and outputs return to their reset values.
- **Latency:**
  - `start` is sampled high at edge 0.
  - `busy=1` for cycles 1..WIDTH.
  - `done=1` in cycle WIDTH+1.
  - Total: WIDTH+1 cycles from start to done.
- **Throughput:** the earliest next start is sampled in IDLE, at edge WIDTH+2, i.e. one operation per WIDTH+2 cycles.
- `busy` and `done` are registered (decoded from the state register). They are never high together.
- Operand inputs may change freely after the start edge.

## Structure
- **Shared package `arith_pkg`:**
  - State enum `sub_state_t` {IDLE, RUN, DONE}.
  - Constant `SUB_DEFAULT_WIDTH = 8`.
- **Sub-module `full_subtractor`:** purely combinational, ports `a`, `b`, `bin` → `d`, `bout`. It is instantiated once and is reusable by other serial arithmetic blocks.
- **Top level:** FSM, shift registers, borrow flop, and counter.

## Test plan
All scenarios use WIDTH=8.

- **5 − 3:** `a=0x05`, `b=0x03`, start one cycle → `done` 9 cycles later, `diff=0x02`, `borrow=0`; `busy` high exactly 8 cycles.
- **Underflow and wrap:**
  - `a=0x03`, `b=0x05` → `diff=0xFE`, `borrow=1`.
  - `a=0x00`, `b=0x01` → `diff=0xFF`, `borrow=1`.
- **Equal and full-range:**
  - `a=0xFF`, `b=0xFF` → `diff=0x00`, `borrow=0`.
  - `a=0xFF`, `b=0x00` → `diff=0xFF`, `borrow=0`.
- **Start ignored when not in IDLE:**
  - Start `a=0x10`, `b=0x01`.
  - Pulse `start` with `a=0x00`, `b=0xFF` at RUN cycle 4 and again in the DONE cycle.
  - Expect a single `done` with `diff=0x0F`, `borrow=0`, and no second operation.
- **Reset mid-operation:** assert `rst` asynchronously at RUN cycle 3 → `busy`, `done`, `diff`, `borrow` all 0 immediately, with no `done` pulse. A new start afterwards (`a=0x80`, `b=0x7F`) → `diff=0x01`, `borrow=0`.
- **Back-to-back with random operands:**
  - Issue start at the first IDLE cycle after each `done`, for 256 random operand pairs.
  - Compare against `(a - b) & 0xFF` and `a < b`.
  - Check the result holds stable between `done` and the next start.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks.
//   sub_state_t        : serial_subtractor FSM states
//   SUB_DEFAULT_WIDTH  : default operand width for serial_subtractor
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int unsigned SUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the column borrows.
// Ports:
//   a, b  : minuend / subtrahend bit
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   start        : request, accepted only in IDLE; captures a and b
//   a, b         : minuend and subtrahend
//   busy         : high while bits are being processed
//   done         : one-cycle pulse when diff/borrow are final
//   diff, borrow : (a - b) mod 2^WIDTH and a < b; held until the next accepted start
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  sub_state_t       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             done_q;

  logic d_bit;
  logic bout_bit;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_q      <= {1'b0, a_q[WIDTH-1:1]};
          b_q      <= {1'b0, b_q[WIDTH-1:1]};
          // Result bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
          diff_q   <= {d_bit, diff_q[WIDTH-1:1]};
          borrow_q <= bout_bit;
          if (cnt_q == LastBit) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
